// File: rtl/bg_pkg.sv
// Shared types, colours and the pattern colour lookup for the background pattern generator.
package bg_pkg;

    typedef enum logic [1:0] {
        SOLID    = 2'd0,
        CHECKER  = 2'd1,
        HSTRIPES = 2'd2,
        SCROLL   = 2'd3
    } bg_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FLASH = 2'd2
    } flash_state_t;

    localparam logic [7:0] BASE_COLOR  = 8'hE4;
    localparam logic [7:0] ALT_COLOR   = 8'h00;
    localparam logic [7:0] FLASH_COLOR = 8'hFF;

    // SCROLL shares the checker lookup; only its column input differs.
    function automatic logic [7:0] pattern_color(input bg_mode_t mode,
                                                 input logic     parity,
                                                 input logic     stripe);
        logic [7:0] color;
        case (mode)
            SOLID:    color = BASE_COLOR;
            HSTRIPES: color = stripe ? ALT_COLOR : BASE_COLOR;
            default:  color = parity ? ALT_COLOR : BASE_COLOR;
        endcase
        return color;
    endfunction

endpackage

// File: rtl/bg_flash_fsm.sv
// Frame-counted border-flash sequencer: IDLE -> ARMED -> FLASH for FLASH_FRAMES frames.
module bg_flash_fsm
    import bg_pkg::*;
#(
    parameter int FLASH_FRAMES = 30
) (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic flashReq,
    output logic flashActive,
    output logic flashPhase
);

    localparam logic [7:0] LAST_FRAME = 8'(FLASH_FRAMES - 1);

    flash_state_t state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (flashReq) state_d = ARMED;
            end
            ARMED: begin
                if (startOfFrame) begin
                    state_d = FLASH;
                    cnt_d   = '0;
                end
            end
            FLASH: begin
                // A restart request outranks the terminating frame boundary.
                if (flashReq) begin
                    cnt_d = '0;
                end else if (startOfFrame) begin
                    if (cnt_q == LAST_FRAME) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign flashActive = (state_q == FLASH);
    assign flashPhase  = cnt_q[2];

endmodule

// File: rtl/back_ground_pattern_gen.sv
// Frame-synchronous background pattern drawer with border brackets and border flash.
// Optional feature: define BG_SCROLL_EN to build the scrolling checker and its counter.
module back_ground_pattern_gen
    import bg_pkg::*;
#(
    parameter int X_FRAME_SIZE   = 639,
    parameter int Y_FRAME_SIZE   = 479,
    parameter int BRACKET_OFFSET = 3,
    parameter int TILE_LOG2      = 5,
    parameter int FLASH_FRAMES   = 30
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic [1:0]  modeSel,
    input  logic        modeLoad,
    input  logic        flashReq,
    output logic [7:0]  BG_RGB,
    output logic        boardersDrawReq,
    output logic        flashActive
);

    localparam logic [10:0] BR_NEAR = 11'(BRACKET_OFFSET);
    localparam logic [10:0] BR_X    = 11'(X_FRAME_SIZE - BRACKET_OFFSET);
    localparam logic [10:0] BR_Y    = 11'(Y_FRAME_SIZE - BRACKET_OFFSET);

    bg_mode_t    pending_q, pending_d;
    bg_mode_t    active_q, active_d;
    logic [10:0] x_eff;
    logic        parity;
    logic        bracket;
    logic [7:0]  rgb_d, rgb_q;
    logic        br_q;
    logic        fa_q;
    logic        fsm_active;
    logic        fsm_phase;

    // active_d is the mode of the pixel presented this cycle, so a new mode
    // already applies to the first pixel of the frame that adopts it.
    always_comb begin
        pending_d = modeLoad     ? bg_mode_t'(modeSel) : pending_q;
        active_d  = startOfFrame ? pending_d           : active_q;
    end

`ifdef BG_SCROLL_EN
    logic [10:0] scroll_q, scroll_d;

    always_comb begin
        scroll_d = scroll_q;
        if (startOfFrame && active_q == SCROLL) scroll_d = scroll_q + 11'd1;
        x_eff = (active_d == SCROLL) ? pixelX + scroll_d : pixelX;
    end

    always_ff @(posedge clk) begin
        if (!resetN) scroll_q <= '0;
        else         scroll_q <= scroll_d;
    end
`else
    assign x_eff = pixelX;
`endif

    assign parity  = x_eff[TILE_LOG2] ^ pixelY[TILE_LOG2];
    assign bracket = (pixelX == BR_NEAR) || (pixelY == BR_NEAR) ||
                     (pixelX == BR_X)    || (pixelY == BR_Y);

    always_comb begin
        rgb_d = pattern_color(active_d, parity, pixelY[TILE_LOG2]);
        if (bracket && fsm_active && !fsm_phase) rgb_d = FLASH_COLOR;
    end

    bg_flash_fsm #(
        .FLASH_FRAMES (FLASH_FRAMES)
    ) u_flash (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .flashReq     (flashReq),
        .flashActive  (fsm_active),
        .flashPhase   (fsm_phase)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            pending_q <= SOLID;
            active_q  <= SOLID;
            rgb_q     <= FLASH_COLOR;
            br_q      <= 1'b0;
            fa_q      <= 1'b0;
        end else begin
            pending_q <= pending_d;
            active_q  <= active_d;
            rgb_q     <= rgb_d;
            br_q      <= bracket;
            fa_q      <= fsm_active;
        end
    end

    assign BG_RGB          = rgb_q;
    assign boardersDrawReq = br_q;
    assign flashActive     = fa_q;

endmodule

// File: doc/back_ground_pattern_gen.md
# back_ground_pattern_gen

Parametrised successor to the fixed single-colour background drawer. It paints the VGA background as one of four frame-synchronous patterns: solid, checkerboard, horizontal stripes, or scrolling checker. It also raises the per-pixel border-bracket request and runs a frame-counted border-flash sequencer. It sits between the VGA sync/pixel counter and the object-priority mux, with the same 8-bit RGB332 output as the other drawers.

## Interface
Parameters:
- X_FRAME_SIZE, 639: last visible pixel column.
- Y_FRAME_SIZE, 479: last visible pixel row.
- BRACKET_OFFSET, 3: distance of bracket lines from the frame edge.
- TILE_LOG2, 5: log2 of the tile edge in pixels (range 1..8).
- FLASH_FRAMES, 30: number of frames in one flash sequence (range 1..255).

Ports:
- clk  in  1  pixel clock; the block's only clock.
- resetN  in  1  synchronous, active-low reset, sampled on posedge clk.
- pixelX  in  11  current pixel column.
- pixelY  in  11  current pixel row.
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame.
- modeSel  in  2  requested pattern: 0 SOLID, 1 CHECKER, 2 HSTRIPES, 3 SCROLL.
- modeLoad  in  1  pulse; captures modeSel into the pending register.
- flashReq  in  1  pulse; requests a border flash.
- BG_RGB  out  8  background colour {R[2:0],G[2:0],B[1:0]}.
- boardersDrawReq  out  1  high on bracket pixels.
- flashActive  out  1  high while the flash FSM is in FLASH.

## Operation
- Colours: BASE = R111 G001 B00 (8'hE4); ALT = 8'h00; FLASH_COL = 8'hFF.
- Mode registers:
  - pendingMode loads on modeLoad.
  - activeMode loads pendingMode on startOfFrame only, so there is no mid-frame tearing.
  - If modeLoad and startOfFrame coincide, the new value is used directly (pendingMode and activeMode both take it).
- Tile parity: parity = pixelX[TILE_LOG2] ^ pixelY[TILE_LOG2]. In SCROLL, pixelX is replaced by (pixelX + scrollCnt), truncated to 11 bits.
- Pattern selection:
  - SOLID: BASE.
  - CHECKER / SCROLL: BASE if parity is 0, else ALT.
  - HSTRIPES: BASE if pixelY[TILE_LOG2] is 0, else ALT.
- scrollCnt:
  - 11-bit counter, +1 on each startOfFrame while activeMode is SCROLL.
  - Wraps 2047 -> 0.
  - Holds its value in other modes.
- Bracket: boardersDrawReq = 1 when pixelX == BRACKET_OFFSET, or pixelY == BRACKET_OFFSET, or pixelX == X_FRAME_SIZE-BRACKET_OFFSET, or pixelY == Y_FRAME_SIZE-BRACKET_OFFSET.
- Flash FSM states and transitions:
  - IDLE -> ARMED on flashReq.
  - ARMED -> FLASH on startOfFrame; flashCnt loads 0.
  - FLASH: flashCnt +1 on each startOfFrame. When flashCnt == FLASH_FRAMES-1 and startOfFrame, go to IDLE.
  - flashReq in ARMED is ignored. flashReq in FLASH clears flashCnt to 0 (restart). If flashReq coincides with the terminating startOfFrame, restart wins and the FSM stays in FLASH.
- Flash colour: in FLASH, bracket pixels with flashCnt[2] == 0 output FLASH_COL instead of the pattern. Otherwise bracket pixels show the pattern colour.
- Reset mid-frame or mid-flash: all state returns to reset values on the next edge. There is no partial-frame recovery.

## Timing
- Latency: exactly 1 cycle. BG_RGB and boardersDrawReq at edge N+1 reflect the pixelX/pixelY/state present at edge N.
- Mode and scroll changes are visible from the first pixel of the frame that starts with the qualifying startOfFrame; that pixel's output appears 1 cycle later.
- flashActive is registered. It rises 1 cycle after the startOfFrame edge that enters FLASH and falls 1 cycle after the exit edge.
- Reset values:
  - BG_RGB = 8'hFF, boardersDrawReq = 0, flashActive = 0.
  - pendingMode = activeMode = SOLID.
  - scrollCnt = 0, flashCnt = 0, FSM = IDLE.
- Arithmetic: all comparisons are 11-bit unsigned. Parameter expressions are evaluated as int and compared after truncation to 11 bits.

## Configuration
- Macro BG_SCROLL_EN:
  - Defined: SCROLL mode and scrollCnt are implemented as specified.
  - Undefined: scrollCnt and the adder are removed, and modeSel = 3 behaves exactly as CHECKER.

## Structure
- Package bg_pkg holds:
  - typedef enum bg_mode_t {SOLID, CHECKER, HSTRIPES, SCROLL};
  - typedef enum flash_state_t {IDLE, ARMED, FLASH};
  - localparams BASE_COLOR, ALT_COLOR, FLASH_COLOR.
- Sub-module bg_flash_fsm contains the flash FSM and flashCnt. Inputs: clk, resetN, startOfFrame, flashReq. Outputs: flashActive, flashPhase (= flashCnt[2]).

## Test plan
- Reset held 3 cycles, then released with pixel (0,0) -> BG_RGB 8'hFF during reset; 8'hE4 one cycle after release; boardersDrawReq 0.
- SOLID, sweep pixel (3,100), (636,5), (100,476) -> boardersDrawReq 1 one cycle later for each; BG_RGB 8'hE4.
- modeSel=1, modeLoad mid-frame -> still SOLID until the next startOfFrame. Then pixel (32,0) gives 8'h00 and (32,32) gives 8'hE4.
- SCROLL with BG_SCROLL_EN, 5 frames -> scrollCnt = 5; pixel (27,0) outputs 8'h00 (27+5 = 32). Without the macro, same pixel outputs 8'hE4.
- flashReq, then FLASH_FRAMES=30 frames -> flashActive high for exactly 30 frames. Bracket pixel (3,3) is 8'hFF in frames 0-3, is not 8'hFF in frames 4-7, and is 8'hFF again in frames 8-11.
- flashReq in frame 20 of a flash -> flashCnt restarts at 0; flashActive stays high 30 more frames.
